// File: rtl/mult_block_reducer.sv
// Burst reducer: requests a block read, sums the streamed products and
// optionally tracks the maximum word (compile with REDUCER_MAX_TRACK_EN).
module mult_block_reducer #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 64,
    parameter int IDX_W     = $clog2(NUM_WORDS),
    parameter int SUM_W     = DATA_W + IDX_W,
    parameter int TIMEOUT   = 255
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              EN_reduce,
    output logic              RDY_reduce,
    output logic              EN_blockRead,
    input  logic              VALID_memVal,
    input  logic [DATA_W-1:0] memVal_data,
    output logic              VALID_result,
    output logic [SUM_W-1:0]  result_sum,
    output logic [DATA_W-1:0] result_max,
    output logic [IDX_W-1:0]  result_maxIdx,
    output logic              ERR_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_WORDS - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, COLLECT, DONE} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [WD_W-1:0]   wd_q;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  res_sum_q;
    logic              rdy_q, blk_q, vld_q, err_q;
    logic              beat, last;

    assign beat  = (state_q == COLLECT) && VALID_memVal;
    assign last  = beat && (cnt_q == LAST_BEAT);
    assign acc_d = acc_q + SUM_W'(memVal_data);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            acc_q     <= '0;
            res_sum_q <= '0;
            rdy_q     <= 1'b0;
            blk_q     <= 1'b0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            blk_q <= 1'b0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rdy_q && EN_reduce) begin
                        state_q <= REQ;
                        rdy_q   <= 1'b0;
                        blk_q   <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        wd_q    <= '0;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                REQ: state_q <= COLLECT;
                COLLECT: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + IDX_W'(1);
                        wd_q  <= '0;
                        if (last) begin
                            state_q   <= DONE;
                            res_sum_q <= acc_d;
                            vld_q     <= 1'b1;
                        end
                    end else if (wd_q == WD_LAST) begin
                        // abort: results from the previous burst stay put
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef REDUCER_MAX_TRACK_EN
    logic [DATA_W-1:0] max_q, max_d, res_max_q;
    logic [IDX_W-1:0]  idx_q, idx_d, res_idx_q;

    // strict compare keeps the earliest index on ties
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (cnt_q == '0 || memVal_data > max_q) begin
            max_d = memVal_data;
            idx_d = cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            max_q     <= '0;
            idx_q     <= '0;
            res_max_q <= '0;
            res_idx_q <= '0;
        end else if (beat) begin
            max_q <= max_d;
            idx_q <= idx_d;
            if (last) begin
                res_max_q <= max_d;
                res_idx_q <= idx_d;
            end
        end
    end

    assign result_max    = res_max_q;
    assign result_maxIdx = res_idx_q;
`else
    assign result_max    = '0;
    assign result_maxIdx = '0;
`endif

    assign RDY_reduce   = rdy_q;
    assign EN_blockRead = blk_q;
    assign VALID_result = vld_q;
    assign ERR_timeout  = err_q;
    assign result_sum   = res_sum_q;

endmodule

// File: tb/tb_mult_block_reducer.sv
// Directed bench for mult_block_reducer; max/index expectations follow
// REDUCER_MAX_TRACK_EN.
module tb_mult_block_reducer;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        EN_reduce = 1'b0;
    logic        VALID_memVal = 1'b0;
    logic [31:0] memVal_data = '0;
    logic        RDY_reduce, EN_blockRead, VALID_result, ERR_timeout;
    logic [37:0] result_sum;
    logic [31:0] result_max;
    logic [5:0]  result_maxIdx;

    int total = 0;
    int bad   = 0;
    int n_blk = 0;
    int n_vld = 0;
    int n_err = 0;
    int s_blk, s_vld, s_err;
    logic [31:0] vec [64];

    mult_block_reducer dut (
        .CLK(CLK), .rst(rst), .EN_reduce(EN_reduce),
        .RDY_reduce(RDY_reduce), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
        .VALID_result(VALID_result), .result_sum(result_sum),
        .result_max(result_max), .result_maxIdx(result_maxIdx),
        .ERR_timeout(ERR_timeout)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (EN_blockRead) n_blk <= n_blk + 1;
        if (VALID_result) n_vld <= n_vld + 1;
        if (ERR_timeout)  n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        s_blk = n_blk;
        s_vld = n_vld;
        s_err = n_err;
    endtask

    // returns in the first COLLECT cycle
    task automatic start();
        for (int k = 0; k < 20 && !RDY_reduce; k++) tick();
        chk("start_rdy", RDY_reduce, 1);
        EN_reduce = 1'b1;
        tick();
        EN_reduce = 1'b0;
        chk("req_blk", EN_blockRead, 1);
        chk("req_rdy", RDY_reduce, 0);
        tick();
        chk("col_blk", EN_blockRead, 0);
    endtask

    task automatic beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            VALID_memVal = 1'b1;
            memVal_data  = vec[i];
            tick();
            VALID_memVal = 1'b0;
            if (gaps && ((i + 1) % 8 == 0) && (i != n - 1)) begin
                repeat (3) tick();
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [37:0] sum,
                                input logic [31:0] mx, input logic [5:0] ix);
        chk({tag, "_vld"}, VALID_result, 1);
        chk({tag, "_sum"}, result_sum, sum);
`ifdef REDUCER_MAX_TRACK_EN
        chk({tag, "_max"}, result_max, mx);
        chk({tag, "_idx"}, result_maxIdx, ix);
`else
        chk({tag, "_max"}, result_max, 0);
        chk({tag, "_idx"}, result_maxIdx, 0);
`endif
        tick();
        chk({tag, "_vld_drop"}, VALID_result, 0);
        chk({tag, "_rdy"}, RDY_reduce, 1);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        chk("rst_rdy", RDY_reduce, 0);
        chk("rst_blk", EN_blockRead, 0);
        chk("rst_vld", VALID_result, 0);
        chk("rst_err", ERR_timeout, 0);
        chk("rst_sum", result_sum, 0);
        chk("rst_max", result_max, 0);
        chk("rst_idx", result_maxIdx, 0);
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", RDY_reduce, 1);

        // ramp 2*i
        for (int i = 0; i < 64; i++) vec[i] = 32'(2 * i);
        snap();
        start();
        beats(64, 1'b0);
        check_result("ramp", 38'd4032, 32'd126, 6'd63);
        chk("ramp_nblk", n_blk - s_blk, 1);

        // all ones, tie keeps first index
        for (int i = 0; i < 64; i++) vec[i] = 32'hFFFF_FFFF;
        start();
        beats(64, 1'b0);
        check_result("full", 38'h3F_FFFF_FFC0, 32'hFFFF_FFFF, 6'd0);

        // value 5 with 3-cycle gaps every 8 beats
        for (int i = 0; i < 64; i++) vec[i] = 32'd5;
        snap();
        start();
        beats(64, 1'b1);
        check_result("gaps", 38'd320, 32'd5, 6'd0);
        chk("gaps_noerr", n_err - s_err, 0);

        // stall after 10 beats
        for (int i = 0; i < 64; i++) vec[i] = 32'd7;
        snap();
        start();
        beats(10, 1'b0);
        k = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (ERR_timeout) begin
                k = c;
                break;
            end
        end
        chk("to_cycles", k, 255);
        chk("to_rdy_low", RDY_reduce, 0);
        chk("to_sum_kept", result_sum, 320);
`ifdef REDUCER_MAX_TRACK_EN
        chk("to_max_kept", result_max, 5);
`endif
        tick();
        chk("to_err_drop", ERR_timeout, 0);
        chk("to_rdy", RDY_reduce, 1);
        chk("to_novld", n_vld - s_vld, 0);
        chk("to_nerr", n_err - s_err, 1);

        // reset mid-burst, stray beats afterwards
        for (int i = 0; i < 64; i++) vec[i] = 32'd1;
        snap();
        start();
        beats(10, 1'b0);
        rst = 1'b1;
        VALID_memVal = 1'b1;
        memVal_data  = 32'd1;
        tick();
        chk("mrst_rdy", RDY_reduce, 0);
        chk("mrst_sum", result_sum, 0);
        chk("mrst_max", result_max, 0);
        rst = 1'b0;
        for (int i = 0; i < 53; i++) tick();
        VALID_memVal = 1'b0;
        chk("mrst_rdy_up", RDY_reduce, 1);
        chk("mrst_sum_idle", result_sum, 0);
        chk("mrst_idx_idle", result_maxIdx, 0);
        chk("mrst_novld", n_vld - s_vld, 0);
        chk("mrst_noerr", n_err - s_err, 0);
        start();
        beats(64, 1'b0);
        check_result("ones", 38'd64, 32'd1, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_block_reducer.md
# mult_block_reducer

Downstream consumer of the multiplier's block-read port. On request it pulses `EN_blockRead`, collects the `NUM_WORDS` products streamed back on `memVal_data`/`VALID_memVal`, and reduces them to a widened unsigned sum plus an optional running maximum and its index. It then presents the result with a one-cycle valid pulse. A watchdog aborts the burst if the multiplier stalls.

## Interface
- `DATA_W`, 32: width of each product word.
- `NUM_WORDS`, 64: words per burst; must be a power of two, ≥2.
- `IDX_W`, `$clog2(NUM_WORDS)` = 6: beat and index width.
- `SUM_W`, `DATA_W+IDX_W` = 38: sum width.
- `TIMEOUT`, 255: maximum idle cycles between beats; ≥1.

Ports:
- `CLK`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `EN_reduce`  in  1  start request; accepted only while `RDY_reduce`=1.
- `RDY_reduce`  out  1  block is idle and can accept a start.
- `EN_blockRead`  out  1  one-cycle pulse to the multiplier.
- `VALID_memVal`  in  1  qualifies `memVal_data`.
- `memVal_data`  in  DATA_W  product word.
- `VALID_result`  out  1  one-cycle pulse; result outputs are valid.
- `result_sum`  out  SUM_W  unsigned sum of all words in the burst.
- `result_max`  out  DATA_W  unsigned maximum word.
- `result_maxIdx`  out  IDX_W  beat index of `result_max`.
- `ERR_timeout`  out  1  one-cycle pulse; the burst was aborted.

## Operation
- FSM states: IDLE, REQ, COLLECT, DONE.
- IDLE: `RDY_reduce`=1. If `EN_reduce`=1, go to REQ and clear the accumulator, beat counter and watchdog.
- REQ: `EN_blockRead`=1 for exactly this cycle. Unconditionally go to COLLECT.
- COLLECT: each cycle with `VALID_memVal`=1 is one beat:
  - sum += zero-extended word;
  - beat counter +1;
  - watchdog cleared.
- Max tracking updates on strictly greater, so ties keep the earliest index. Beat 0 always loads max and index.
- On the beat with counter = `NUM_WORDS-1`, go to DONE.
- COLLECT with no beat: watchdog +1. When the watchdog reaches `TIMEOUT`, go to IDLE and pulse `ERR_timeout`. The results are not updated.
- DONE: register the final sum/max/idx to the outputs and pulse `VALID_result`. Go to IDLE.
- `VALID_memVal` is ignored in IDLE, REQ and DONE. Stray or extra beats are dropped.
- Arithmetic is unsigned. `SUM_W` makes overflow impossible: `NUM_WORDS·(2^DATA_W−1)` < `2^SUM_W`.
- Result outputs hold their value until the next DONE. They are not cleared by a start or a timeout.

## Timing
- Reset values:
  - `RDY_reduce`=0, `EN_blockRead`=0, `VALID_result`=0, `ERR_timeout`=0;
  - `result_sum`/`result_max`/`result_maxIdx`=0;
  - state IDLE.
- `RDY_reduce` is registered. It rises the first cycle after `rst` falls.
- Start latency: `EN_reduce` sampled high at edge t gives `RDY_reduce`=0 and `EN_blockRead`=1 in cycle t+1. COLLECT begins at t+2.
- Result latency: final beat sampled at edge c gives `VALID_result`=1 with results in cycle c+1. `RDY_reduce`=1 in c+2.
- Timeout: with no beats, `ERR_timeout` is high in the cycle after the `TIMEOUT`-th consecutive idle COLLECT cycle. `RDY_reduce`=1 one cycle later.
- `EN_reduce` held high continuously: a new burst starts every time IDLE is reached. There is no dead cycle beyond IDLE itself.
- `rst` mid-burst: the next cycle is IDLE with all outputs at their reset values. No `VALID_result` and no `ERR_timeout` are produced. Remaining incoming beats are ignored.
- `rst` has priority over every other input in the same cycle.

## Configuration
- Macro: `REDUCER_MAX_TRACK_EN`.
- Defined: max/index tracking is compiled in, as described above.
- Undefined: the max comparator and registers are removed. `result_max` and `result_maxIdx` are tied to 0. Sum, FSM and timing are unchanged.

## Test plan
- Burst of 64 consecutive beats, data = 2·i (i=0..63) → `VALID_result` pulse with `result_sum`=4032, `result_max`=126, `result_maxIdx`=63, exactly 1 `EN_blockRead` pulse.
- 64 beats of 0xFFFFFFFF → `result_sum`=0x3F_FFFF_FFC0, `result_max`=0xFFFFFFFF, `result_maxIdx`=0 (tie keeps the first index).
- 64 beats of value 5, with `VALID_memVal` low for 3 cycles after every 8th beat → `result_sum`=320, no `ERR_timeout`, `VALID_result` the cycle after the 64th beat.
- Start, then 10 beats, then `VALID_memVal` held low → `ERR_timeout` pulse after 255 idle cycles, no `VALID_result`, previous results unchanged, `RDY_reduce`=1 the cycle after.
- `rst` asserted after 10 beats, then 54 further beats driven → no output pulses, all outputs 0, `RDY_reduce`=1 after `rst` falls. A following full burst of 1s → `result_sum`=64.
- `REDUCER_MAX_TRACK_EN` undefined, data = 2·i → `result_sum`=4032, `result_max`=0, `result_maxIdx`=0.
